ioctl_rom_router: RTL and testbench

- Parametrised ROM download router for the MiSTer ioctl stream; replaces per-game hand-coded address selectors and index-filtered write strobes.
- Matches each downloaded byte against a table of (index, base, size) regions and packs bytes into 1/2/4-byte words.
- Buffers the packed words in a small FIFO and presents them with a one-hot region select and a ready/valid handshake towards the ROMs/SDRAM.
- Sits between the framework ioctl bus and game-board ROM write ports; tracks per-region completion and errors.

---
 rtl/ioctl_rom_router_if.sv | 29 ++
 rtl/ioctl_rom_router.sv | 171 +++++++++++++++++
 tb/tb_ioctl_rom_router.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ioctl_rom_router_if.sv
// ioctl download bus and ROM write port of the ROM download router.
// master = framework/host side, slave = router side.
interface ioctl_rom_router_if #(
  parameter int NUM_REGIONS = 12,
  parameter int WORD_BYTES  = 1,
  parameter int ADDR_W      = 16
);
  logic                    ioctl_download;
  logic [7:0]              ioctl_index;
  logic [24:0]             ioctl_addr;
  logic [7:0]              ioctl_data;
  logic                    ioctl_wr;
  logic                    ioctl_wait;
  logic [ADDR_W-1:0]       rom_addr;
  logic [8*WORD_BYTES-1:0] rom_data;
  logic [NUM_REGIONS-1:0]  rom_cs;
  logic                    rom_wr;
  logic                    rom_ready;

  modport master (
    output ioctl_download, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr, rom_ready,
    input  ioctl_wait, rom_addr, rom_data, rom_cs, rom_wr
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_addr, ioctl_data, ioctl_wr, rom_ready,
    output ioctl_wait, rom_addr, rom_data, rom_cs, rom_wr
  );
endinterface

// File: rtl/ioctl_rom_router.sv
// Routes ioctl download bytes into per-region ROM words: region match, byte
// packing, a small word FIFO and a ready/valid ROM write port.
module ioctl_rom_router #(
  parameter int                        NUM_REGIONS  = 12,
  parameter int                        WORD_BYTES   = 1,
  parameter int                        ADDR_W       = 16,
  parameter logic [8*NUM_REGIONS-1:0]  REGION_INDEX = '0,
  parameter logic [25*NUM_REGIONS-1:0] REGION_BASE  = '0,
  parameter logic [25*NUM_REGIONS-1:0] REGION_SIZE  = {NUM_REGIONS{25'h1000}},
  parameter int                        FIFO_DEPTH   = 4
) (
  input  logic                   clk_49m,
  input  logic                   reset,
  ioctl_rom_router_if.slave      bus,
  output logic [NUM_REGIONS-1:0] region_done,
  output logic [1:0]             err,
  output logic                   dl_active
);
  localparam int          RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int          DW = 8 * WORD_BYTES;
  localparam int          PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW = PW + 1;
  localparam int unsigned NR = NUM_REGIONS;
  localparam int unsigned WB = WORD_BYTES;

  // Region match
  logic              hit;
  logic [RW-1:0]     hit_idx;
  logic [24:0]       off;
  logic              hit_last;
  int unsigned       hit_lane;
  logic [ADDR_W-1:0] hit_word;

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    off      = '0;
    hit_last = 1'b0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (!hit && bus.ioctl_index == REGION_INDEX[8*i +: 8]
          && {1'b0, bus.ioctl_addr} >= {1'b0, REGION_BASE[25*i +: 25]}
          && {1'b0, bus.ioctl_addr} <  {1'b0, REGION_BASE[25*i +: 25]} + {1'b0, REGION_SIZE[25*i +: 25]}) begin
        hit      = 1'b1;
        hit_idx  = RW'(i);
        off      = bus.ioctl_addr - REGION_BASE[25*i +: 25];
        hit_last = (off == REGION_SIZE[25*i +: 25] - 25'd1);
      end
    end
    hit_lane = 32'(off) % WB;
    hit_word = ADDR_W'(32'(off) / WB);
  end

  // Packer and FIFO state
  logic              dl_q;
  logic              pk_valid, pk_full, pk_last;
  logic [RW-1:0]     pk_region;
  logic [ADDR_W-1:0] pk_word;
  logic [DW-1:0]     pk_data;

  logic [ADDR_W-1:0] mem_addr   [FIFO_DEPTH];
  logic [DW-1:0]     mem_data   [FIFO_DEPTH];
  logic [RW-1:0]     mem_region [FIFO_DEPTH];
  logic              mem_last   [FIFO_DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     count, count_next;
  logic              wait_q;

  logic matched, differ, dl_rise, dl_fall;
  logic push, pop, empty, full, accept, pk_valid_next;
  logic [DW-1:0] fresh_data, merge_data;

  assign matched = bus.ioctl_wr && hit;
  assign differ  = (pk_region != hit_idx) || (pk_word != hit_word);
  assign dl_rise = bus.ioctl_download && !dl_q;
  assign dl_fall = !bus.ioctl_download && dl_q;
  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = bus.rom_ready && !empty;
  // A new byte for another word pushes the held word on the same edge it loads.
  assign push    = pk_valid && (pk_full || dl_fall || (matched && differ));
  assign accept  = push && (!full || pop);
  assign pk_valid_next = matched || (pk_valid && !push);

  always_comb begin
    fresh_data = '0;
    merge_data = pk_data;
    for (int unsigned b = 0; b < WB; b++) begin
      if (hit_lane == b) begin
        fresh_data[8*b +: 8] = bus.ioctl_data;
        merge_data[8*b +: 8] = bus.ioctl_data;
      end
    end
  end

  always_comb begin
    count_next = count;
    if (accept && !pop)
      count_next = count + 1'b1;
    else if (!accept && pop)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      dl_q        <= 1'b0;
      pk_valid    <= 1'b0;
      pk_full     <= 1'b0;
      pk_last     <= 1'b0;
      pk_region   <= '0;
      pk_word     <= '0;
      pk_data     <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      wait_q      <= 1'b0;
      region_done <= '0;
      err         <= '0;
    end else begin
      dl_q <= bus.ioctl_download;

      if (matched) begin
        pk_valid  <= 1'b1;
        pk_full   <= (hit_lane == WB - 1);
        pk_region <= hit_idx;
        pk_word   <= hit_word;
        if (push || !pk_valid) begin
          pk_data <= fresh_data;
          pk_last <= hit_last;
        end else begin
          pk_data <= merge_data;
          pk_last <= pk_last | hit_last;
        end
      end else if (push) begin
        pk_valid <= 1'b0;
        pk_full  <= 1'b0;
        pk_last  <= 1'b0;
        pk_data  <= '0;
      end

      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      count  <= count_next;
      wait_q <= ({1'b0, count_next} + (CW+1)'(pk_valid_next)) >= (CW+1)'(FIFO_DEPTH - 1);

      // Clears first so that a same-cycle event still records.
      if (dl_rise) begin
        region_done <= '0;
        err         <= '0;
      end
      if (bus.ioctl_wr && !hit) err[0] <= 1'b1;
      if (push && !accept)      err[1] <= 1'b1;
      if (pop && mem_last[rptr]) region_done[mem_region[rptr]] <= 1'b1;
    end
  end

  always_ff @(posedge clk_49m) begin
    if (accept) begin
      mem_addr[wptr]   <= pk_word;
      mem_data[wptr]   <= pk_data;
      mem_region[wptr] <= pk_region;
      mem_last[wptr]   <= pk_last;
    end
  end

  assign bus.rom_wr     = !empty;
  assign bus.rom_addr   = empty ? '0 : mem_addr[rptr];
  assign bus.rom_data   = empty ? '0 : mem_data[rptr];
  assign bus.rom_cs     = empty ? '0 : (NUM_REGIONS'(1'b1) << mem_region[rptr]);
  assign bus.ioctl_wait = wait_q;
  assign dl_active      = bus.ioctl_download || !empty || pk_valid;
endmodule

// File: tb/tb_ioctl_rom_router.sv
// Directed bench for ioctl_rom_router: a byte-wide and a 16-bit-word instance.
module tb_ioctl_rom_router;
  localparam logic [31:0]  IDX  = {8'd3, 8'd3, 8'd1, 8'd0};
  localparam logic [99:0]  BASE = {25'h4000, 25'h4000, 25'h2000, 25'h0};
  localparam logic [99:0]  SIZE = {25'h100, 25'h10, 25'h1000, 25'h1000};

  logic clk = 1'b0;
  logic reset;
  logic [3:0] done_a, done_b;
  logic [1:0] err_a, err_b;
  logic       act_a, act_b;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ioctl_rom_router_if #(.NUM_REGIONS(4), .WORD_BYTES(1), .ADDR_W(16)) bus_a ();
  ioctl_rom_router_if #(.NUM_REGIONS(4), .WORD_BYTES(2), .ADDR_W(16)) bus_b ();

  ioctl_rom_router #(
    .NUM_REGIONS(4), .WORD_BYTES(1), .ADDR_W(16),
    .REGION_INDEX(IDX), .REGION_BASE(BASE), .REGION_SIZE(SIZE), .FIFO_DEPTH(4)
  ) dut_a (
    .clk_49m(clk), .reset(reset), .bus(bus_a.slave),
    .region_done(done_a), .err(err_a), .dl_active(act_a)
  );

  ioctl_rom_router #(
    .NUM_REGIONS(4), .WORD_BYTES(2), .ADDR_W(16),
    .REGION_INDEX(IDX), .REGION_BASE(BASE), .REGION_SIZE(SIZE), .FIFO_DEPTH(4)
  ) dut_b (
    .clk_49m(clk), .reset(reset), .bus(bus_b.slave),
    .region_done(done_b), .err(err_b), .dl_active(act_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_a(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    bus_a.ioctl_index = idx;
    bus_a.ioctl_addr  = addr;
    bus_a.ioctl_data  = data;
    bus_a.ioctl_wr    = 1'b1;
    tick();
    bus_a.ioctl_wr    = 1'b0;
  endtask

  task automatic strobe_b(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    bus_b.ioctl_index = idx;
    bus_b.ioctl_addr  = addr;
    bus_b.ioctl_data  = data;
    bus_b.ioctl_wr    = 1'b1;
    tick();
    bus_b.ioctl_wr    = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus_a.ioctl_download = 1'b0; bus_a.ioctl_index = '0; bus_a.ioctl_addr = '0;
    bus_a.ioctl_data = '0; bus_a.ioctl_wr = 1'b0; bus_a.rom_ready = 1'b1;
    bus_b.ioctl_download = 1'b0; bus_b.ioctl_index = '0; bus_b.ioctl_addr = '0;
    bus_b.ioctl_data = '0; bus_b.ioctl_wr = 1'b0; bus_b.rom_ready = 1'b1;
    tick();
    tick();

    check("rst_wr",   32'(bus_a.rom_wr), 32'h0);
    check("rst_cs",   32'(bus_a.rom_cs), 32'h0);
    check("rst_addr", 32'(bus_a.rom_addr), 32'h0);
    check("rst_data", 32'(bus_a.rom_data), 32'h0);
    check("rst_wait", 32'(bus_a.ioctl_wait), 32'h0);
    check("rst_done", 32'(done_a), 32'h0);
    check("rst_err",  32'(err_a), 32'h0);
    check("rst_act",  32'(act_a), 32'h0);

    reset = 1'b0;
    bus_a.ioctl_download = 1'b1;
    bus_b.ioctl_download = 1'b1;
    tick();

    // Byte-wide latency and last-byte completion
    strobe_a(8'd0, 25'h0FFF, 8'hA5);
    check("lat_n1_wr", 32'(bus_a.rom_wr), 32'h0);
    tick();
    check("lat_wr",   32'(bus_a.rom_wr), 32'h1);
    check("lat_cs",   32'(bus_a.rom_cs), 32'h1);
    check("lat_addr", 32'(bus_a.rom_addr), 32'h0FFF);
    check("lat_data", 32'(bus_a.rom_data), 32'hA5);
    tick();
    check("done0",    32'(done_a), 32'h1);
    check("pop_wr",   32'(bus_a.rom_wr), 32'h0);

    // Overlapping regions: lowest number wins
    strobe_a(8'd3, 25'h4005, 8'h5A);
    tick();
    check("r2_cs",   32'(bus_a.rom_cs), 32'h4);
    check("r2_addr", 32'(bus_a.rom_addr), 32'h5);
    check("r2_data", 32'(bus_a.rom_data), 32'h5A);
    tick();
    strobe_a(8'd3, 25'h4020, 8'h6B);
    tick();
    check("r3_cs",   32'(bus_a.rom_cs), 32'h8);
    check("r3_addr", 32'(bus_a.rom_addr), 32'h20);
    tick();
    strobe_a(8'd3, 25'h400F, 8'h77);
    tick();
    check("r2l_cs",  32'(bus_a.rom_cs), 32'h4);
    tick();
    check("done02",  32'(done_a), 32'h5);

    // Unmatched bytes, then clear on new download
    strobe_a(8'd2, 25'h0010, 8'h99);
    check("unm_err", 32'(err_a), 32'h1);
    tick();
    check("unm_wr",  32'(bus_a.rom_wr), 32'h0);
    strobe_a(8'd0, 25'h1000, 8'h98);
    tick();
    check("oor_wr",  32'(bus_a.rom_wr), 32'h0);
    check("oor_err", 32'(err_a), 32'h1);
    bus_a.ioctl_download = 1'b0;
    tick();
    bus_a.ioctl_download = 1'b1;
    tick();
    check("clr_err",  32'(err_a), 32'h0);
    check("clr_done", 32'(done_a), 32'h0);

    // FIFO overflow with the sink stalled
    bus_a.rom_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      strobe_a(8'd0, 25'(32'h100 + k), 8'(32'h10 + k));
      if (k == 1) check("wait_lo", 32'(bus_a.ioctl_wait), 32'h0);
      if (k == 2) check("wait_hi", 32'(bus_a.ioctl_wait), 32'h1);
    end
    tick();
    check("ovf_err",  32'(err_a), 32'h2);
    check("ovf_act",  32'(act_a), 32'h1);
    bus_a.rom_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_wr",   32'(bus_a.rom_wr), 32'h1);
      check("drain_addr", 32'(bus_a.rom_addr), 32'h100 + 32'(k));
      check("drain_data", 32'(bus_a.rom_data), 32'h10 + 32'(k));
      tick();
    end
    check("drain_end",  32'(bus_a.rom_wr), 32'h0);
    check("drain_wait", 32'(bus_a.ioctl_wait), 32'h0);

    // Reset with words queued
    bus_a.rom_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      strobe_a(8'd0, 25'(32'h200 + k), 8'(32'h20 + k));
    tick();
    tick();
    bus_a.ioctl_download = 1'b0;
    tick();
    check("q_wr",   32'(bus_a.rom_wr), 32'h1);
    check("q_act",  32'(act_a), 32'h1);
    check("q_wait", 32'(bus_a.ioctl_wait), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("ar_wr",   32'(bus_a.rom_wr), 32'h0);
    check("ar_act",  32'(act_a), 32'h0);
    check("ar_cs",   32'(bus_a.rom_cs), 32'h0);
    check("ar_wait", 32'(bus_a.ioctl_wait), 32'h0);
    #2 reset = 1'b0;
    bus_a.rom_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_wr", 32'(bus_a.rom_wr), 32'h0);
    end

    // 16-bit words
    bus_b.ioctl_download = 1'b0;
    tick();
    bus_b.ioctl_download = 1'b1;
    tick();
    strobe_b(8'd1, 25'h2004, 8'h11);
    strobe_b(8'd1, 25'h2005, 8'h22);
    tick();
    check("w2_wr",   32'(bus_b.rom_wr), 32'h1);
    check("w2_addr", 32'(bus_b.rom_addr), 32'h2);
    check("w2_data", 32'(bus_b.rom_data), 32'h2211);
    check("w2_cs",   32'(bus_b.rom_cs), 32'h2);
    tick();
    check("w2_pop",  32'(bus_b.rom_wr), 32'h0);

    strobe_b(8'd1, 25'h2006, 8'h33);
    tick();
    check("part_wr",  32'(bus_b.rom_wr), 32'h0);
    check("part_act", 32'(act_b), 32'h1);
    bus_b.ioctl_download = 1'b0;
    tick();
    check("fl_wr",   32'(bus_b.rom_wr), 32'h1);
    check("fl_addr", 32'(bus_b.rom_addr), 32'h3);
    check("fl_data", 32'(bus_b.rom_data), 32'h0033);
    tick();
    check("fl_pop",  32'(bus_b.rom_wr), 32'h0);
    check("fl_act",  32'(act_b), 32'h0);

    bus_b.ioctl_download = 1'b1;
    tick();
    strobe_b(8'd1, 25'h2008, 8'h44);
    strobe_b(8'd1, 25'h200A, 8'h55);
    check("nw_wr",   32'(bus_b.rom_wr), 32'h1);
    check("nw_addr", 32'(bus_b.rom_addr), 32'h4);
    check("nw_data", 32'(bus_b.rom_data), 32'h0044);
    tick();
    check("nw_hold", 32'(bus_b.rom_wr), 32'h0);
    bus_b.ioctl_download = 1'b0;
    tick();
    check("nw2_addr", 32'(bus_b.rom_addr), 32'h5);
    check("nw2_data", 32'(bus_b.rom_data), 32'h0055);
    check("b_err",    32'(err_b), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
